// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory access controller: maps load/store requests onto a
// word-addressed, byte-enabled single-port SRAM with req/gnt and rvalid handshake.
module dmem_access_ctrl #(
    parameter int unsigned MEM_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    input  logic [2:0]        req_type_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              misalign_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i
);
    localparam logic [2:0] T_LB  = 3'd0;
    localparam logic [2:0] T_LH  = 3'd1;
    localparam logic [2:0] T_LW  = 3'd2;
    localparam logic [2:0] T_LBU = 3'd3;
    localparam logic [2:0] T_LHU = 3'd4;
    localparam logic [2:0] T_SB  = 3'd5;
    localparam logic [2:0] T_SH  = 3'd6;
    localparam logic [2:0] T_SW  = 3'd7;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_DONE, S_ERR} state_t;

    state_t            state_q;
    logic [2:0]        type_q;
    logic [1:0]        off_q;
    logic              done_q, misalign_q, mem_req_q, mem_we_q;
    logic [3:0]        mem_be_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q, rdata_q;

    logic              is_byte_c, is_half_c, is_store_c, aligned_c;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic [7:0]        lbyte_c;
    logic [15:0]       lhalf_c;
    logic [31:0]       load_c;
    logic              capture_c;
    logic              unused_c;

    // Request decode: size, alignment, lane enables and replicated store data
    always_comb begin
        is_byte_c  = (req_type_i == T_LB) || (req_type_i == T_LBU) || (req_type_i == T_SB);
        is_half_c  = (req_type_i == T_LH) || (req_type_i == T_LHU) || (req_type_i == T_SH);
        is_store_c = (req_type_i == T_SB) || (req_type_i == T_SH) || (req_type_i == T_SW);
        aligned_c  = is_byte_c || (is_half_c ? !req_addr_i[0] : (req_addr_i[1:0] == 2'b00));
        be_c       = 4'b1111;
        wdata_c    = req_wdata_i;
        if (is_byte_c) begin
            be_c    = 4'b0001 << req_addr_i[1:0];
            wdata_c = {4{req_wdata_i[7:0]}};
        end else if (is_half_c) begin
            be_c    = 4'b0011 << req_addr_i[1:0];
            wdata_c = {2{req_wdata_i[15:0]}};
        end
    end

    // Load lane extraction and extension from the latched type/offset
    always_comb begin
        lbyte_c = 8'(mem_rdata_i >> {off_q, 3'b000});
        lhalf_c = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (type_q)
            T_LB:    load_c = {{24{lbyte_c[7]}}, lbyte_c};
            T_LH:    load_c = {{16{lhalf_c[15]}}, lhalf_c};
            T_LBU:   load_c = {24'd0, lbyte_c};
            T_LHU:   load_c = {16'd0, lhalf_c};
            T_LW:    load_c = mem_rdata_i;
            default: load_c = mem_rdata_i;
        endcase
    end

    assign capture_c = mem_rvalid_i && !(type_q inside {T_SB, T_SH, T_SW}) &&
                       ((state_q == S_RESP) || ((state_q == S_REQ) && mem_gnt_i));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            type_q      <= 3'd0;
            off_q       <= 2'd0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
        end else begin
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        if (aligned_c) begin
                            state_q     <= S_REQ;
                            type_q      <= req_type_i;
                            off_q       <= req_addr_i[1:0];
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_store_c;
                            mem_be_q    <= be_c;
                            mem_addr_q  <= req_addr_i[MEM_AW+1:2];
                            mem_wdata_q <= wdata_c;
                        end else begin
                            state_q    <= S_ERR;
                            misalign_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        if (mem_rvalid_i) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (mem_rvalid_i) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (capture_c) begin
                rdata_q <= load_c;
            end
        end
    end

    // Stall is combinational in IDLE so the request's first cycle is already frozen
    assign stall_o     = ((state_q == S_IDLE) && req_valid_i) || (state_q == S_REQ) || (state_q == S_RESP);
    assign done_o      = done_q;
    assign misalign_o  = misalign_q;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign unused_c    = ^req_addr_i[31:MEM_AW+2];

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized bench for dmem_access_ctrl: the bench plays the SRAM, predicts every
// cycle's outputs from a transaction timeline and checks them on the falling edge.
module tb_dmem_access_ctrl;
    localparam int unsigned MEM_AW = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid_i;
    logic [2:0]        req_type_i;
    logic [31:0]       req_addr_i;
    logic [31:0]       req_wdata_i;
    logic              stall_o, done_o, misalign_o;
    logic [31:0]       rdata_o;
    logic              mem_req_o, mem_we_o;
    logic [3:0]        mem_be_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_gnt_i, mem_rvalid_i;
    logic [31:0]       mem_rdata_i;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.MEM_AW(MEM_AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_type_i(req_type_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .misalign_o(misalign_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle expectations, written by the stimulus process
    logic              chk_en = 1'b0;
    logic              e_stall, e_done, e_mis, e_req, e_we, e_memzero;
    logic [3:0]        e_be;
    logic [MEM_AW-1:0] e_addr;
    logic [31:0]       e_wdata, e_rdata;
    int                acc_cyc, lat_done, lat_mis;
    logic              cap_we;
    logic [3:0]        cap_be;
    logic [MEM_AW-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic [31:0]       mem_model [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(stall_o), 32'(e_stall));
            chk("done", 32'(done_o), 32'(e_done));
            chk("misalign", 32'(misalign_o), 32'(e_mis));
            chk("mem_req", 32'(mem_req_o), 32'(e_req));
            chk("rdata", rdata_o, e_rdata);
            if (e_req || e_memzero) begin
                chk("mem_we", 32'(mem_we_o), 32'(e_memzero ? 1'b0 : e_we));
                chk("mem_be", 32'(mem_be_o), 32'(e_memzero ? 4'd0 : e_be));
                chk("mem_addr", 32'(mem_addr_o), 32'(e_memzero ? '0 : e_addr));
                chk("mem_wdata", mem_wdata_o, e_memzero ? 32'd0 : e_wdata);
            end
            if (mem_req_o) begin
                cap_we = mem_we_o; cap_be = mem_be_o; cap_addr = mem_addr_o; cap_wdata = mem_wdata_o;
            end
            if (done_o)     lat_done = cyc - acc_cyc;
            if (misalign_o) lat_mis  = cyc - acc_cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int size_of(input logic [2:0] t);
        if (t == 3'd0 || t == 3'd3 || t == 3'd5) return 1;
        if (t == 3'd1 || t == 3'd4 || t == 3'd6) return 2;
        return 4;
    endfunction

    task automatic idle_exp();
        e_stall = 1'b0; e_done = 1'b0; e_mis = 1'b0; e_req = 1'b0;
    endtask

    task automatic noise();
        mem_gnt_i    = 1'($urandom_range(0, 1));
        mem_rvalid_i = 1'($urandom_range(0, 1));
        mem_rdata_i  = $urandom;
    endtask

    // One complete access: g = cycles grant is withheld, r = cycles from grant to rvalid (0 = same cycle)
    task automatic do_access(input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd,
                             input int g, input int r);
        logic        st, uns, ok;
        int          sz, off, idx;
        logic [3:0]  be;
        logic [31:0] wexp, word, mask, ld;
        st   = (t >= 3'd5);
        uns  = (t == 3'd3 || t == 3'd4);
        sz   = size_of(t);
        off  = int'(a[1:0]);
        ok   = (off % sz) == 0;
        idx  = int'(a[MEM_AW+1:2]);
        for (int i = 0; i < 4; i++) begin
            be[i] = (i >= off) && (i < off + sz);
            wexp[8*i +: 8] = wd[8*(i % sz) +: 8];
        end
        if (!mem_model.exists(idx)) mem_model[idx] = $urandom;
        word = mem_model[idx];
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
        ld   = (word >> (8*off)) & mask;
        if (!uns && sz < 4 && ld[8*sz-1]) ld = ld | ~mask;

        // cycle 0: request presented in IDLE
        acc_cyc = cyc; lat_done = -1; lat_mis = -1;
        req_valid_i = 1'b1; req_type_i = t; req_addr_i = a; req_wdata_i = wd;
        noise();
        idle_exp(); e_stall = 1'b1;
        if (!ok) begin
            step();
            noise();
            idle_exp(); e_mis = 1'b1;
            step();
            req_valid_i = 1'b0; req_addr_i = $urandom; req_type_i = 3'($urandom);
            noise();
            idle_exp();
            return;
        end
        step();
        e_memzero = 1'b0;
        e_req = 1'b1; e_we = st; e_be = be; e_addr = a[MEM_AW+1:2]; e_wdata = wexp;
        for (int i = 0; i <= g; i++) begin
            if (i > 0) step();
            mem_gnt_i    = (i == g);
            mem_rvalid_i = (i == g) ? (r == 0) : 1'($urandom_range(0, 1));
            mem_rdata_i  = (i == g && r == 0 && !st) ? word : $urandom;
        end
        if (st) begin
            for (int i = 0; i < 4; i++) if (be[i]) mem_model[idx][8*i +: 8] = wexp[8*i +: 8];
        end
        step();
        e_req = 1'b0;
        for (int j = 1; j <= r; j++) begin
            mem_gnt_i    = 1'($urandom_range(0, 1));
            mem_rvalid_i = (j == r);
            mem_rdata_i  = (j == r && !st) ? word : $urandom;
            step();
        end
        // DONE cycle
        noise();
        e_stall = 1'b0; e_done = 1'b1;
        if (!st) e_rdata = ld;
        step();
        req_valid_i = 1'b0; req_addr_i = $urandom; req_type_i = 3'($urandom);
        noise();
        idle_exp();
    endtask

    initial begin
        logic [2:0]  t;
        logic [31:0] a;
        reset = 1'b1; req_valid_i = 1'b0; req_type_i = 3'd0; req_addr_i = 32'd0; req_wdata_i = 32'd0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
        idle_exp(); e_we = 1'b0; e_be = 4'd0; e_addr = '0; e_wdata = 32'd0;
        e_rdata = 32'd0; e_memzero = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        step();

        // LW 0x10, SRAM word 4 = DEADBEEF, gnt first REQ cycle, rvalid next
        mem_model[4] = 32'hDEAD_BEEF;
        do_access(3'd2, 32'h0000_0010, 32'd0, 0, 1);
        chk("lw_lat", 32'(lat_done), 32'd3);
        chk("lw_addr", 32'(cap_addr), 32'd4);
        chk("lw_be", 32'(cap_be), 32'hF);
        chk("lw_we", 32'(cap_we), 32'd0);
        chk("lw_rdata", rdata_o, 32'hDEAD_BEEF);

        // LB / LBU from 0x13 with top byte 0x80
        mem_model[4] = 32'h8012_3456;
        do_access(3'd0, 32'h0000_0013, 32'd0, 0, 1);
        chk("lb_be", 32'(cap_be), 32'h8);
        chk("lb_rdata", rdata_o, 32'hFFFF_FF80);
        do_access(3'd3, 32'h0000_0013, 32'd0, 0, 1);
        chk("lbu_rdata", rdata_o, 32'h0000_0080);

        // SH 0x1234ABCD to 0x6
        do_access(3'd6, 32'h0000_0006, 32'h1234_ABCD, 0, 1);
        chk("sh_we", 32'(cap_we), 32'd1);
        chk("sh_be", 32'(cap_be), 32'hC);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh_addr", 32'(cap_addr), 32'd1);
        chk("sh_rdata_held", rdata_o, 32'h0000_0080);

        // Grant withheld 5 cycles, then gnt+rvalid together
        do_access(3'd2, 32'h0000_0010, 32'd0, 5, 0);
        chk("wait_lat", 32'(lat_done), 32'd7);
        chk("wait_rdata", rdata_o, 32'h8012_3456);

        // Misaligned LW @2, LH @3
        do_access(3'd2, 32'h0000_0002, 32'd0, 0, 1);
        chk("mis_lw_lat", 32'(lat_mis), 32'd1);
        do_access(3'd1, 32'h0000_0003, 32'd0, 0, 1);
        chk("mis_lh_lat", 32'(lat_mis), 32'd1);
        chk("mis_lh_done", 32'(lat_done), 32'hFFFF_FFFF);

        // Reset during REQ
        req_valid_i = 1'b1; req_type_i = 3'd2; req_addr_i = 32'h0000_0020; req_wdata_i = 32'd0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        idle_exp(); e_stall = 1'b1;
        step();
        e_memzero = 1'b0; e_req = 1'b1; e_we = 1'b0; e_be = 4'hF; e_addr = 10'd8;
        e_wdata = 32'd0;
        step();
        reset = 1'b1; req_valid_i = 1'b0;
        step();
        idle_exp(); e_rdata = 32'd0; e_memzero = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_req", 32'(mem_req_o), 32'd0);

        // Randomized traffic, mostly aligned, with random grant/response delays
        for (int n = 0; n < 250; n++) begin
            t = 3'($urandom);
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) a = a & ~32'(size_of(t) - 1);
            do_access(t, a, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) step();
        end

        step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Data-memory access controller for the five-stage pipeline's MEM stage. It turns a load/store request (type, byte address, store data) into a word-addressed, byte-enabled transaction on a single-port SRAM with a request/grant and response-valid handshake. It stalls the pipeline while the transaction is outstanding and returns sign- or zero-extended load data. Misaligned accesses are rejected without touching memory.

## Interface
Parameters:
- MEM_AW, 10, SRAM word-address width; word address = req_addr_i[MEM_AW+1:2].

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid_i  in  1  MEM-stage access request; held stable with type/addr/wdata until done_o or misalign_o
- req_type_i  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
- req_addr_i  in  32  byte address (ALU result)
- req_wdata_i  in  32  store data, right-justified
- stall_o  out  1  freeze IF..EXE and the MEM pipeline register
- done_o  out  1  one-cycle pulse: access complete
- rdata_o  out  32  extended load data; valid while done_o=1, holds until next done_o
- misalign_o  out  1  one-cycle pulse: access rejected as misaligned
- mem_req_o  out  1  SRAM request, held until mem_gnt_i
- mem_we_o  out  1  1 = write
- mem_be_o  out  4  byte enables, bit i = byte lane i
- mem_addr_o  out  MEM_AW  word address
- mem_wdata_o  out  32  store data replicated to the addressed lanes
- mem_gnt_i  in  1  SRAM accepted the request this cycle
- mem_rvalid_i  in  1  SRAM response: read data valid or write acknowledged
- mem_rdata_i  in  32  SRAM read word

## Operation
- Five-state FSM: IDLE, REQ, RESP, DONE, ERR.
- IDLE:
  - With req_valid_i=1 and the access aligned: latch type, addr[1:0], be, word address and wdata; go to REQ.
  - With req_valid_i=1 and the access misaligned: go to ERR.
  - Alignment rules: halfword needs addr[0]=0; word needs addr[1:0]=00; byte is always aligned.
- REQ: mem_req_o=1.
  - mem_gnt_i=1 and mem_rvalid_i=0: go to RESP.
  - mem_gnt_i=1 and mem_rvalid_i=1 in the same cycle: go to DONE.
  - Otherwise stay in REQ.
- RESP: on mem_rvalid_i=1, go to DONE.
- On the rvalid capture edge for a load, update rdata_o with the extended value.
- DONE: done_o=1; return to IDLE.
- ERR: misalign_o=1; return to IDLE. No SRAM activity.
- Byte enables:
  - byte: 0001 << addr[1:0]
  - half: 0011 << addr[1:0]
  - word: 1111
  - Loads use the same be as the equivalent store.
- Write data:
  - SB: wdata[7:0] replicated ×4
  - SH: wdata[15:0] replicated ×2
  - SW: unchanged
- Load extraction:
  - Select lane addr[1:0] (byte) or addr[1] (half).
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- stall_o = (state==IDLE & req_valid_i) | state==REQ | state==RESP. Combinational in IDLE, so the stall appears in the request's first cycle.
- stall_o is 0 in DONE and ERR, so the pipeline advances on that edge. The next request is sampled in the following IDLE cycle.
- mem_rvalid_i outside RESP and REQ is ignored. mem_gnt_i outside REQ is ignored.

## Timing
- All outputs are registered except stall_o.
- Reset values:
  - state IDLE
  - stall_o 0, done_o 0, misalign_o 0
  - rdata_o 0
  - mem_req_o 0, mem_we_o 0, mem_be_o 0000, mem_addr_o 0, mem_wdata_o 0
- mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o are valid whenever mem_req_o=1 and stable until grant.
- Best-case latency, with gnt in the first REQ cycle and rvalid one cycle later:
  - cycle 0: IDLE, accept
  - cycle 1: REQ, gnt
  - cycle 2: RESP, rvalid
  - cycle 3: DONE, done_o=1
- Total: 4 cycles, stalled in cycles 0–2.
- Best case with gnt and rvalid together: 3 cycles.
- Misaligned access: cycle 0 IDLE, cycle 1 ERR with misalign_o=1. Stalled in cycle 0 only.
- Reset asserted mid-transaction: next edge forces IDLE with all outputs at reset values, and any pending response is dropped. The SRAM shares the reset.
- Back-to-back requests: minimum spacing is one IDLE cycle after each DONE or ERR.

## Test plan
- Reset: assert reset for 2 cycles during REQ -> state IDLE, mem_req_o=0, stall_o=0, rdata_o=0.
- LW from 0x0000_0010, SRAM holds 0xDEAD_BEEF, gnt at REQ cycle 1, rvalid the next cycle:
  - mem_addr_o=4, mem_be_o=1111, mem_we_o=0
  - done_o at cycle 3, rdata_o=0xDEAD_BEEF
  - stall_o high for cycles 0–2
- LB and LBU from 0x0000_0013, same word 0x80xx_xxxx -> be=1000; LB rdata_o=0xFFFF_FF80, LBU rdata_o=0x0000_0080.
- SH data 0x1234_ABCD to 0x0000_0006 -> mem_we_o=1, be=1100, mem_wdata_o=0xABCD_ABCD, mem_addr_o=1; done_o after rvalid ack.
- Grant withheld 5 cycles -> mem_req_o and the address held stable for 5 cycles, stall_o continuous; gnt and rvalid together -> DONE next cycle.
- LW at 0x0000_0002 and LH at 0x0000_0003 -> misalign_o pulse one cycle after request, mem_req_o never asserted, done_o=0.
